audio_dac_out: RTL and testbench



---
 rtl/audio_dac_out.sv | 191 +++++++++++++++++++
 tb/tb_audio_dac_out.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_out.sv
// audio_dac_out: interpolating, volume-ramped
// second-order sigma-delta audio output stage.
module audio_dac_out #(
    parameter int DIV_LOG2  = 10,
    parameter int RAMP_LOG2 = 8,
    parameter int CLAMP     = 28672
) (
    input  logic        clk48,
    input  logic        rst,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    input  logic [7:0]  volume,
    input  logic        mute,
    output logic        out,
    output logic        underrun,
    output logic        muted
);

    localparam int ACC_W = DIV_LOG2 + 18;

    localparam logic [DIV_LOG2:0] PH_DONE =
        {1'b1, {DIV_LOG2{1'b0}}};
    localparam logic [DIV_LOG2:0] PH_LAST =
        {1'b0, {DIV_LOG2{1'b1}}};

    localparam logic signed [16:0] Y_MAX = 17'(CLAMP);
    localparam logic signed [16:0] Y_MIN = 17'(-CLAMP);

    localparam logic signed [20:0] I1_HI = 21'sd524287;
    localparam logic signed [20:0] I1_LO = -21'sd524288;
    localparam logic signed [24:0] I2_HI = 25'sd8388607;
    localparam logic signed [24:0] I2_LO = -25'sd8388608;

    typedef enum logic [1:0] {
        S_MUTED,
        S_RAMP,
        S_PLAY
    } state_t;

    logic signed [16:0]      x;
    logic signed [16:0]      prev;
    logic signed [16:0]      delta;
    logic signed [16:0]      interp;
    logic signed [16:0]      acc_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] delta_ext;
    logic [DIV_LOG2:0]       phase;

    state_t                  state;
    logic [7:0]              vol_cur;
    logic [7:0]              target;
    logic [RAMP_LOG2-1:0]    tick_cnt;
    logic                    tick;

    logic signed [25:0]      prod;
    logic signed [16:0]      y_raw;
    logic signed [16:0]      y;

    logic signed [17:0]      fb;
    logic signed [19:0]      i1;
    logic signed [23:0]      i2;
    logic signed [20:0]      i1_sum;
    logic signed [24:0]      i2_sum;
    logic signed [19:0]      i1_nx;
    logic signed [23:0]      i2_nx;

    // offset binary -> two's complement, sign-extended to 17 bits
    assign x = {{2{~sample_in[15]}}, sample_in[14:0]};

    assign delta_ext = ACC_W'(delta);
    assign acc_q     = 17'(acc >>> DIV_LOG2);
    assign interp    = prev + acc_q;

    always_ff @(posedge clk48) begin
        if (rst) begin
            prev     <= '0;
            delta    <= '0;
            acc      <= '0;
            phase    <= PH_DONE;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (sample_valid) begin
                prev  <= interp;
                delta <= x - interp;
                acc   <= '0;
                phase <= '0;
            end else if (!phase[DIV_LOG2]) begin
                acc   <= acc + delta_ext;
                phase <= phase + 1'b1;
                if (phase == PH_LAST) begin
                    underrun <= 1'b1;
                end
            end
        end
    end

    assign tick   = &tick_cnt;
    assign target = mute ? 8'd0 : volume;

    always_ff @(posedge clk48) begin
        if (rst) begin
            state    <= S_MUTED;
            vol_cur  <= 8'd0;
            tick_cnt <= '0;
            muted    <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
            unique case (state)
                S_MUTED: begin
                    vol_cur <= 8'd0;
                    if (target != 8'd0) begin
                        state <= S_RAMP;
                        muted <= 1'b0;
                    end
                end
                S_RAMP: begin
                    if (vol_cur == target &&
                        target != 8'd0) begin
                        state <= S_PLAY;
                    end else if (vol_cur == 8'd0 &&
                                 target == 8'd0) begin
                        state <= S_MUTED;
                        muted <= 1'b1;
                    end else if (tick) begin
                        if (vol_cur < target) begin
                            vol_cur <= vol_cur + 8'd1;
                        end else begin
                            vol_cur <= vol_cur - 8'd1;
                        end
                    end
                end
                S_PLAY: begin
                    if (target != vol_cur) begin
                        state <= S_RAMP;
                    end
                end
                default: begin
                    state <= S_MUTED;
                    muted <= 1'b1;
                end
            endcase
        end
    end

    assign prod  = 26'(interp) *
                   26'(signed'({1'b0, vol_cur}));
    assign y_raw = 17'(prod >>> 8);

    always_comb begin
        y = y_raw;
        if (y_raw > Y_MAX) begin
            y = Y_MAX;
        end else if (y_raw < Y_MIN) begin
            y = Y_MIN;
        end
    end

    assign fb = out ? 18'sd32768 : -18'sd32768;

    // second integrator consumes the freshly updated first one
    always_comb begin
        i1_sum = 21'(i1) + 21'(y) - 21'(fb);
        i1_nx  = 20'(i1_sum);
        if (i1_sum > I1_HI) begin
            i1_nx = 20'(I1_HI);
        end else if (i1_sum < I1_LO) begin
            i1_nx = 20'(I1_LO);
        end
        i2_sum = 25'(i2) + 25'(i1_nx) - 25'(fb);
        i2_nx  = 24'(i2_sum);
        if (i2_sum > I2_HI) begin
            i2_nx = 24'(I2_HI);
        end else if (i2_sum < I2_LO) begin
            i2_nx = 24'(I2_LO);
        end
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            i1  <= '0;
            i2  <= '0;
            out <= 1'b0;
        end else begin
            i1  <= i1_nx;
            i2  <= i2_nx;
            out <= ~i2_nx[23];
        end
    end

endmodule

// File: tb/tb_audio_dac_out.sv
// tb_audio_dac_out: directed vectors with a
// cycle-stamped scoreboard for audio_dac_out.
module tb_audio_dac_out;

    logic        clk48 = 1'b0;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [7:0]  volume;
    logic        mute;
    logic        out;
    logic        underrun;
    logic        muted;

    audio_dac_out #(
        .DIV_LOG2  (10),
        .RAMP_LOG2 (4),
        .CLAMP     (28672)
    ) dut (
        .clk48        (clk48),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .volume       (volume),
        .mute         (mute),
        .out          (out),
        .underrun     (underrun),
        .muted        (muted)
    );

    always #5 clk48 = ~clk48;

    int cyc = 0;
    always @(posedge clk48) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        int    val;
        string tag;
    } vchk_t;

    vchk_t vq[$];
    int    uq[$];
    int    total = 0;
    int    bad   = 0;
    int    last_ip = 0;
    int    maxd = 0;
    int    sat_hits = 0;
    bit    watch = 1'b0;

    task automatic check(string tag, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d",
                     tag, act, exp);
        end
    endtask

    task automatic check_rng(string tag, int act,
                             int lo, int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d..%0d",
                     tag, act, lo, hi);
        end
    endtask

    function automatic void push_v(int c, int v, string t);
        vchk_t e;
        e.cyc = c;
        e.val = v;
        e.tag = t;
        vq.push_back(e);
    endfunction

    // monitor: pops expectations as the DUT reaches them
    always @(negedge clk48) begin
        int    ip;
        int    d;
        int    eu;
        vchk_t e;
        ip = dut.interp;
        if (!rst) begin
            if (underrun) begin
                if (uq.size() == 0) begin
                    check("underrun_unexpected", cyc, -1);
                end else begin
                    eu = uq.pop_front();
                    check("underrun_cycle", cyc, eu);
                end
            end
            while (vq.size() > 0 && vq[0].cyc <= cyc) begin
                e = vq.pop_front();
                if (e.cyc != cyc) begin
                    check({e.tag, "_late"}, cyc, e.cyc);
                end else begin
                    check(e.tag, ip, e.val);
                end
            end
            d = ip - last_ip;
            if (d < 0) d = -d;
            if (watch && d > maxd) maxd = d;
            if (dut.i1 == 20'h7FFFF || dut.i1 == 20'h80000 ||
                dut.i2 == 24'h7FFFFF || dut.i2 == 24'h800000) begin
                sat_hits++;
            end
        end
        last_ip = ip;
    end

    task automatic step(int n);
        repeat (n) @(negedge clk48);
    endtask

    task automatic wait_until(int c);
        while (cyc < c) @(negedge clk48);
    endtask

    task automatic send(input logic [15:0] v, output int s);
        sample_in    = v;
        sample_valid = 1'b1;
        s            = cyc + 1;
    endtask

    task automatic endv();
        @(negedge clk48);
        sample_valid = 1'b0;
    endtask

    task automatic count_ones(int n, output int k);
        k = 0;
        repeat (n) begin
            @(negedge clk48);
            k += int'(out);
        end
    endtask

    task automatic wait_vol(int tgt, int bound, output int el);
        el = 0;
        while (int'(dut.vol_cur) != tgt && el < bound) begin
            @(negedge clk48);
            el++;
        end
    endtask

    task automatic wait_muted(int bound, output int el);
        el = 0;
        while (!muted && el < bound) begin
            @(negedge clk48);
            el++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s1, s2, s3, s4, s5, s6;
        int k;
        int el;
        rst          = 1'b1;
        sample_in    = 16'h8000;
        sample_valid = 1'b0;
        volume       = 8'd0;
        mute         = 1'b1;
        step(4);
        check("rst_out", int'(out), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_muted", int'(muted), 1);
        check("rst_interp", int'(dut.interp), 0);
        rst = 1'b0;

        count_ones(5000, k);
        check_rng("idle_ones", k, 2484, 2516);
        check("idle_muted", int'(muted), 1);

        send(16'h9000, s1);
        uq.push_back(s1 + 1024);
        push_v(s1, 0, "ip_s1_strobe");
        push_v(s1 + 1, 4, "ip_s1_first");
        push_v(s1 + 1024, 4096, "ip_s1_end");
        endv();
        wait_until(s1 + 1029);

        send(16'hB000, s2);
        uq.push_back(s2 + 1024);
        push_v(s2, 4096, "ip_s2_strobe");
        push_v(s2 + 1, 4104, "ip_s2_first");
        push_v(s2 + 512, 8192, "ip_s2_half");
        push_v(s2 + 1024, 12288, "ip_s2_end");
        endv();
        wait_until(s2 + 1100);

        watch = 1'b1;
        send(16'h8000, s3);
        push_v(s3, 12288, "ip_s3_strobe");
        push_v(s3 + 300, 8688, "ip_s3_p300");
        endv();
        wait_until(s3 + 300);
        send(16'hC000, s4);
        uq.push_back(s4 + 1024);
        push_v(s4, 8688, "ip_s4_strobe");
        push_v(s4 + 1, 8695, "ip_s4_first");
        push_v(s4 + 2, 8703, "ip_s4_second");
        push_v(s4 + 1024, 16384, "ip_s4_end");
        endv();
        wait_until(s4 + 1030);
        watch = 1'b0;
        check_rng("early_max_step", maxd, 12, 13);

        volume = 8'd255;
        mute   = 1'b0;
        step(2);
        check("up_muted_fall", int'(muted), 0);
        wait_vol(255, 300 * 16, el);
        check_rng("up_ramp_time", el + 2, 254 * 16, 255 * 16 + 4);
        step(4);
        count_ones(8192, k);
        check_rng("play_density", k, 6095, 6177);

        volume = 8'd128;
        wait_vol(128, 140 * 16, el);
        check_rng("down_ramp_time", el, 126 * 16, 127 * 16 + 4);
        step(4);
        mute = 1'b1;
        step(1024);
        check_rng("mute_mid_vol", int'(dut.vol_cur), 63, 65);
        wait_muted(140 * 16, el);
        check_rng("mute_time", el + 1024, 127 * 16, 128 * 16 + 4);

        mute   = 1'b0;
        volume = 8'd255;
        send(16'hFFFF, s5);
        uq.push_back(s5 + 1024);
        endv();
        wait_vol(255, 300 * 16, el);
        step(16);
        check("clamp_pos_y", int'(dut.y), 28672);
        check("clamp_pos_ip", int'(dut.interp), 32767);
        count_ones(8192, k);
        check_rng("clamp_pos_density", k, 7639, 7721);

        send(16'h0000, s6);
        uq.push_back(s6 + 1024);
        endv();
        wait_until(s6 + 1100);
        check("clamp_neg_y", int'(dut.y), -28672);
        count_ones(8192, k);
        check_rng("clamp_neg_density", k, 471, 553);

        rst          = 1'b1;
        sample_in    = 16'h9000;
        sample_valid = 1'b1;
        @(negedge clk48);
        rst          = 1'b0;
        sample_valid = 1'b0;
        check("mid_rst_out", int'(out), 0);
        check("mid_rst_muted", int'(muted), 1);
        check("mid_rst_underrun", int'(underrun), 0);
        check("mid_rst_interp", int'(dut.interp), 0);
        check("mid_rst_vol", int'(dut.vol_cur), 0);
        step(1100);
        check("post_rst_interp", int'(dut.interp), 0);

        check("ur_queue_left", uq.size(), 0);
        check("ip_queue_left", vq.size(), 0);
        check("integrator_sat", sat_hits, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
